// File: rtl/div_operand_queue_if.sv
// Handshake bundle between an operand producer, the divider operand queue and the divider issue port.
interface div_operand_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [15:0] in_divisor;
    logic [31:0] in_dividend;
    logic        issue_en;
    logic        issue_valid;
    logic        issue_mode;
    logic [15:0] issue_divisor;
    logic [31:0] issue_dividend;

    modport master (
        output in_valid, in_mode, in_divisor, in_dividend, issue_en,
        input  in_ready, issue_valid, issue_mode, issue_divisor, issue_dividend
    );

    modport slave (
        input  in_valid, in_mode, in_divisor, in_dividend, issue_en,
        output in_ready, issue_valid, issue_mode, issue_divisor, issue_dividend
    );
endinterface

// File: rtl/div_operand_queue.sv
// FIFO of pending divide operations feeding a divider one op per cycle with registered issue outputs.
// Optional macro DIV_OPERAND_QUEUE_DZ_CHECK_EN drops divide-by-zero ops and counts them.
module div_operand_queue #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    div_operand_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      dz_err,
    output logic [7:0]                dz_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 49;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE_C = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          issue_valid_r;
    logic          issue_mode_r;
    logic [15:0]   issue_divisor_r;
    logic [31:0]   issue_dividend_r;

    logic          in_ready_s;
    logic          accept_s;
    logic          dz_hit_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;

    // Handshake decode; a zero-divisor op is accepted but never stored when the check is built in
    always_comb begin
        in_ready_s = (count_r < DEPTH_C);
        accept_s   = bus.in_valid && in_ready_s;
`ifdef DIV_OPERAND_QUEUE_DZ_CHECK_EN
        dz_hit_s   = accept_s && (bus.in_divisor == 16'd0);
`else
        dz_hit_s   = 1'b0;
`endif
        push_s     = accept_s && !dz_hit_s;
        pop_s      = bus.issue_en && (count_r != {(AW+1){1'b0}});
        head_s     = mem_r[rd_ptr_r];
    end

    // Entry storage, written at the tail on every stored accept
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.in_mode, bus.in_divisor, bus.in_dividend};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            else        wr_ptr_r <= wr_ptr_r;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            else        rd_ptr_r <= rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue register: head is loaded on pop, data fields hold while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid_r    <= 1'b0;
            issue_mode_r     <= 1'b0;
            issue_divisor_r  <= 16'd0;
            issue_dividend_r <= 32'd0;
        end else if (pop_s) begin
            issue_valid_r    <= 1'b1;
            issue_mode_r     <= head_s[48];
            issue_divisor_r  <= head_s[47:32];
            issue_dividend_r <= head_s[31:0];
        end else begin
            issue_valid_r    <= 1'b0;
            issue_mode_r     <= issue_mode_r;
            issue_divisor_r  <= issue_divisor_r;
            issue_dividend_r <= issue_dividend_r;
        end
    end

`ifdef DIV_OPERAND_QUEUE_DZ_CHECK_EN
    logic       dz_err_r;
    logic [7:0] dz_count_r;

    // Divide-by-zero pulse and saturating drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dz_err_r   <= 1'b0;
            dz_count_r <= 8'd0;
        end else begin
            dz_err_r <= dz_hit_s;
            if (dz_hit_s && (dz_count_r != 8'hFF)) dz_count_r <= dz_count_r + 8'd1;
            else                                   dz_count_r <= dz_count_r;
        end
    end

    assign dz_err   = dz_err_r;
    assign dz_count = dz_count_r;
`else
    assign dz_err   = 1'b0;
    assign dz_count = 8'd0;
`endif

    assign bus.in_ready       = in_ready_s;
    assign bus.issue_valid    = issue_valid_r;
    assign bus.issue_mode     = issue_mode_r;
    assign bus.issue_divisor  = issue_divisor_r;
    assign bus.issue_dividend = issue_dividend_r;
    assign count              = count_r;
endmodule

// File: tb/tb_div_operand_queue.sv
// Directed self-checking bench for div_operand_queue (DEPTH=4), covering both DZ-check builds.
module tb_div_operand_queue;
    logic       clk;
    logic       reset;
    logic [2:0] count;
    logic       dz_err;
    logic [7:0] dz_count;
    int         n_checks;
    int         n_errors;

    div_operand_queue_if bus ();

    div_operand_queue #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .count    (count),
        .dz_err   (dz_err),
        .dz_count (dz_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic [15:0] d, input logic [31:0] n);
        bus.in_valid    = v;
        bus.in_mode     = m;
        bus.in_divisor  = d;
        bus.in_dividend = n;
    endtask

    task automatic check_issue(input string tag, input logic m, input logic [15:0] d, input logic [31:0] n);
        check({tag, ".valid"},    64'(bus.issue_valid),    64'd1);
        check({tag, ".mode"},     64'(bus.issue_mode),     64'(m));
        check({tag, ".divisor"},  64'(bus.issue_divisor),  64'(d));
        check({tag, ".dividend"}, 64'(bus.issue_dividend), 64'(n));
    endtask

    logic        vm [4];
    logic [15:0] vd [4];
    logic [31:0] vn [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        vm[0] = 1'b1; vd[0] = 16'd25443; vn[0] = 32'd690275523;
        vm[1] = 1'b0; vd[1] = 16'd7;     vn[1] = 32'd100;
        vm[2] = 1'b1; vd[2] = 16'd12345; vn[2] = 32'd4000000000;
        vm[3] = 1'b0; vd[3] = 16'd65535; vn[3] = 32'd1;

        reset = 1'b0;
        bus.issue_en = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 32'd0);
        #12;
        check("rst.count", 64'(count), 64'd0);
        check("rst.issue_valid", 64'(bus.issue_valid), 64'd0);
        check("rst.dz_count", 64'(dz_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);

        // single op, one-cycle latency
        bus.issue_en = 1'b1;
        drive(1'b1, 1'b0, 16'd25347, 32'd537133248);
        step();
        check("single.count1", 64'(count), 64'd1);
        check("single.novalid", 64'(bus.issue_valid), 64'd0);
        drive(1'b0, 1'b0, 16'd0, 32'd0);
        step();
        check_issue("single", 1'b0, 16'd25347, 32'd537133248);
        check("single.count0", 64'(count), 64'd0);
        step();
        check("single.pulse", 64'(bus.issue_valid), 64'd0);
        check("single.hold", 64'(bus.issue_dividend), 64'd537133248);

        // stall and fill, fifth push ignored
        bus.issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vm[i], vd[i], vn[i]);
            step();
        end
        check("fill.count", 64'(count), 64'd4);
        check("fill.in_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 1'b1, 16'd9, 32'd999);
        step();
        check("fill.ignored", 64'(count), 64'd4);
        drive(1'b0, 1'b0, 16'd0, 32'd0);
        bus.issue_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_issue($sformatf("drain%0d", i), vm[i], vd[i], vn[i]);
            check($sformatf("drain%0d.count", i), 64'(count), 64'(3 - i));
        end
        step();
        check("drain.idle", 64'(bus.issue_valid), 64'd0);

        // full with simultaneous pop: no push that cycle
        bus.issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vm[i], vd[i], vn[i]);
            step();
        end
        bus.issue_en = 1'b1;
        drive(1'b1, 1'b1, 16'd11, 32'd77);
        step();
        check_issue("fullpop", vm[0], vd[0], vn[0]);
        check("fullpop.count", 64'(count), 64'd3);
        check("fullpop.in_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b0, 1'b0, 16'd0, 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            check_issue($sformatf("fullpop%0d", i), vm[i], vd[i], vn[i]);
        end
        step();
        check("fullpop.empty", 64'(count), 64'd0);
        check("fullpop.idle", 64'(bus.issue_valid), 64'd0);

        // divide-by-zero handling
        bus.issue_en = 1'b0;
        drive(1'b1, 1'b0, 16'd0, 32'd537133248);
        step();
`ifdef DIV_OPERAND_QUEUE_DZ_CHECK_EN
        check("dz.err", 64'(dz_err), 64'd1);
        check("dz.count_after0", 64'(count), 64'd0);
`else
        check("dz.err", 64'(dz_err), 64'd0);
        check("dz.count_after0", 64'(count), 64'd1);
`endif
        drive(1'b1, 1'b1, 16'd3, 32'd537133248);
        step();
        drive(1'b0, 1'b0, 16'd0, 32'd0);
        check("dz.err_pulse", 64'(dz_err), 64'd0);
        bus.issue_en = 1'b1;
`ifdef DIV_OPERAND_QUEUE_DZ_CHECK_EN
        check("dz.dz_count", 64'(dz_count), 64'd1);
        check("dz.count", 64'(count), 64'd1);
`else
        check("dz.dz_count", 64'(dz_count), 64'd0);
        check("dz.count", 64'(count), 64'd2);
        step();
        check_issue("dz.zero_op", 1'b0, 16'd0, 32'd537133248);
`endif
        step();
        check_issue("dz.op3", 1'b1, 16'd3, 32'd537133248);
        step();
        check("dz.idle", 64'(bus.issue_valid), 64'd0);

        // back-to-back issue
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vm[i], vd[i], vn[i]);
            step();
            if (i > 0) check_issue($sformatf("b2b%0d", i - 1), vm[i-1], vd[i-1], vn[i-1]);
            check($sformatf("b2b%0d.count", i), 64'(count), 64'd1);
        end
        drive(1'b0, 1'b0, 16'd0, 32'd0);
        step();
        check_issue("b2b2", vm[2], vd[2], vn[2]);
        check("b2b.count", 64'(count), 64'd0);

        // reset mid-stream
        bus.issue_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vm[i], vd[i], vn[i]);
            step();
        end
        drive(1'b0, 1'b0, 16'd0, 32'd0);
        check("mid.count3", 64'(count), 64'd3);
        #3;
        reset = 1'b0;
        #1;
        check("mid.count", 64'(count), 64'd0);
        check("mid.mode", 64'(bus.issue_mode), 64'd0);
        check("mid.divisor", 64'(bus.issue_divisor), 64'd0);
        check("mid.dividend", 64'(bus.issue_dividend), 64'd0);
        check("mid.dz_count", 64'(dz_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.issue_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid.noissue%0d", i), 64'(bus.issue_valid), 64'd0);
        end
        drive(1'b1, vm[3], vd[3], vn[3]);
        step();
        drive(1'b0, 1'b0, 16'd0, 32'd0);
        step();
        check_issue("mid.new", vm[3], vd[3], vn[3]);

`ifdef DIV_OPERAND_QUEUE_DZ_CHECK_EN
        // drop counter saturation
        bus.issue_en = 1'b0;
        drive(1'b1, 1'b0, 16'd0, 32'd5);
        for (int i = 0; i < 260; i++) step();
        drive(1'b0, 1'b0, 16'd0, 32'd0);
        check("sat.dz_count", 64'(dz_count), 64'd255);
        check("sat.count", 64'(count), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/div_operand_queue.md
DIV_OPERAND_QUEUE -- requirements
Module: div_operand_queue

Interface
REQ-001 The block SHALL have parameter: DEPTH, default 4, number of queued operations (power of 2, minimum 2).
REQ-002 The block SHALL have port: clk  input  1  rising-edge clock, the block's only clock.
REQ-003 The block SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: in_valid  input  1  upstream operation present.
REQ-005 The block SHALL have port: in_ready  output  1  queue can accept an operation.
REQ-006 The block SHALL have port: in_mode  input  1  0 = quotient, 1 = remainder.
REQ-007 The block SHALL have port: in_divisor  input  16  unsigned divisor.
REQ-008 The block SHALL have port: in_dividend  input  32  unsigned dividend.
REQ-009 The block SHALL have port: issue_en  input  1  divider may take an operation this cycle.
REQ-010 The block SHALL have port: issue_valid  output  1  drives the divider's valid_in.
REQ-011 The block SHALL have port: issue_mode  output  1  drives the divider's mode input.
REQ-012 The block SHALL have port: issue_divisor  output  16  drives the divider's divisor input.
REQ-013 The block SHALL have port: issue_dividend  output  32  drives the divider's dividend input.
REQ-014 The block SHALL have port: count  output  log2(DEPTH)+1  number of entries held.
REQ-015 The block SHALL have port: dz_err  output  1  one-cycle pulse, divide-by-zero operation dropped.
REQ-016 The block SHALL have port: dz_count  output  8  saturating count of dropped operations.

Function
REQ-017 The block SHALL drive in_ready = (count < DEPTH), with no push-through when full.
REQ-018 The block SHALL accept an operation on a rising edge when in_valid and in_ready are both 1, and SHALL store {mode, divisor, dividend} at the tail.
REQ-019 On each edge where issue_en=1 and count>0, the block SHALL register the head entry into the issue_* outputs, set issue_valid=1 for exactly one cycle, and pop the entry.
REQ-020 On each edge where issue_en=0 or count=0, the block SHALL set issue_valid=0 and hold issue_mode, issue_divisor and issue_dividend at their last values.
REQ-021 Minimum latency SHALL be 1 cycle: an operation accepted into an empty queue at edge E appears with issue_valid=1 after edge E+1 (no bypass).
REQ-022 A simultaneous accept and pop SHALL leave count unchanged, and issue order SHALL equal accept order.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-024 The block SHALL sustain back-to-back issue: with issue_en held at 1 and the queue fed every cycle, issue_valid SHALL be 1 every cycle.
REQ-025 in_valid while in_ready=0 SHALL be ignored, with no state change.

Reset
REQ-026 reset=0 SHALL asynchronously clear all pointers, count, issue_valid, issue_mode, issue_divisor, issue_dividend, dz_err and dz_count to 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries, and no issue_valid pulse SHALL occur until after the first accept following reset deassertion.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-029 With macro DIV_OPERAND_QUEUE_DZ_CHECK_EN defined, an accepted operation with in_divisor=0 SHALL NOT be stored; dz_err SHALL pulse 1 in the following cycle; dz_count SHALL increment, saturating at 255; in_ready SHALL be unaffected.
REQ-030 With DIV_OPERAND_QUEUE_DZ_CHECK_EN undefined, divisor-0 operations SHALL be queued and issued normally, and dz_err and dz_count SHALL be tied to 0.

Verification
REQ-031 Single op: accept {mode=0, divisor=25347, dividend=537133248} with issue_en=1 -> one cycle later issue_valid=1 with identical fields, count returns to 0.
REQ-032 Stall and fill: issue_en=0, push 5 ops (DEPTH=4) -> in_ready=0 after 4 pushes, count=4, 5th op ignored; then issue_en=1 -> 4 consecutive issue_valid pulses in push order, starting with {1, 25443, 690275523}.
REQ-033 Full with simultaneous pop: count=4, issue_en=1, in_valid=1 -> entry popped, no push that cycle, count=3, in_ready=1 next cycle.
REQ-034 Divide-by-zero (macro on): push {0, 0, 537133248} then {1, 3, 537133248} -> dz_err pulse, dz_count=1, only the divisor-3 op issued; (macro off) both ops issued.
REQ-035 Reset mid-stream: count=3, assert reset=0 asynchronously between edges -> all outputs 0 immediately, no issue after release until new accept.
REQ-036 Saturation (macro on): 260 divisor-0 pushes -> dz_count=255, count stays 0.
